operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
Operand-fetch stage that reads the register file on behalf of the issue path. It accepts decoded instructions over a valid/ready handshake and drives the read-address ports (rd1/rd2) of reg_file, taking rd1_data/rd2_data back. It tracks outstanding writes in a busy-bit scoreboard, bypasses same-cycle writeback data, and stalls on hazards. It delivers operands to the execute stage through a registered valid/ready output.

Parameters:
XLEN, 32, data width of operands and writeback data
NREGS, 32, number of architectural registers; x0 is hardwired zero
AW, 5, register index width, equal to clog2(NREGS)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  decoded instruction present
req_ready  out  1  stage can accept the request this cycle
req_rs1  in  AW  source 1 index
req_rs2  in  AW  source 2 index
req_rd  in  AW  destination index
req_wb  in  1  instruction writes req_rd
rf_rd1  out  AW  reg_file read address 1
rf_rd2  out  AW  reg_file read address 2
rf_rd1_data  in  XLEN  reg_file read data 1, combinational from rf_rd1
rf_rd2_data  in  XLEN  reg_file read data 2, combinational from rf_rd2
wb_valid  in  1  writeback this cycle; same signal that drives reg_file wr_en
wb_rd  in  AW  writeback index
wb_data  in  XLEN  writeback data
out_valid  out  1  operands valid
out_ready  in  1  execute stage accepts
out_op1  out  XLEN  source 1 value
out_op2  out  XLEN  source 2 value
out_rd  out  AW  destination index
out_wb  out  1  destination write flag
busy  out  NREGS  scoreboard, for debug and verification

Behaviour:
- Reset: all stage valids clear; out_valid=0; out_op1/out_op2/out_rd/out_wb=0; busy=0; rf_rd1/rf_rd2=0. A reset mid-operation discards any in-flight entry.
- Two registers:
  - S1 holds the accepted request.
  - OUT holds the operands being presented.
- S1 loads on req_valid && req_ready. rf_rd1/rf_rd2 are driven from S1 rs1/rs2, or 0 when S1 is empty.
- A source is ready when any of these holds:
  - rs==0;
  - busy[rs]==0;
  - wb_valid && wb_rd==rs && wb_rd!=0.
- Source value:
  - 0 when rs==0;
  - wb_data on a writeback match (bypass; reg_file writes at the same edge, so its read data is stale);
  - otherwise rf_rdN_data.
- WAW stall: if S1 wb && rd!=0 && busy[rd] && !(wb_valid && wb_rd==rd), S1 does not advance.
- Advance: S1 advances to OUT when all of the following hold:
  - S1 is valid;
  - both sources are ready;
  - there is no WAW stall;
  - !out_valid || out_ready.
- req_ready = !S1_valid || advance. This is combinational and gives full throughput: 1 instruction per cycle with no hazards.
- Latency: a request accepted at edge N appears with out_valid=1 after edge N+1 at the earliest.
- OUT is held stable while out_valid && !out_ready. out_valid falls after out_ready when no new advance occurs that cycle.
- Scoreboard update at each edge:
  - clear busy[wb_rd] when wb_valid && wb_rd!=0;
  - set busy[S1 rd] on advance when S1 wb && rd!=0;
  - when both hit the same index, set wins (the new producer).
- busy[0] is never set. Writebacks to a non-busy register are legal and leave busy unchanged.
- All index comparisons are exact AW-bit. No width extension of data.

Decomposition:
- Package operand_fetch_pkg holds XLEN, NREGS and AW, plus a packed struct fetch_req_t {rs1, rs2, rd, wb}. reg_file and the bench also use it.
- One sub-module is natural: scoreboard (busy vector, set/clear ports, set-wins priority, x0 masking).
- Bypass/mux logic stays in operand_fetch.

Test Plan:
- No hazard: reg_file x2=50, x10=100; request rs1=2, rs2=10, rd=3, wb=1 -> next cycle out_op1=50, out_op2=100, out_rd=3, and busy[3]=1.
- RAW stall plus bypass: busy[3]=1; request rs1=3 -> out_valid stays 0 and req_ready=0. Then wb_valid, wb_rd=3, wb_data=0x1234 -> next cycle out_op1=0x1234, and busy[3] stays 1 (new producer).
- x0: request rs1=0, rs2=0, rd=0, wb=1 with reg_file entry 0 forced to 0xFFFF -> out_op1=out_op2=0, and busy stays 0.
- Back-pressure: out_ready=0 for 3 cycles with 2 requests queued -> OUT stable, S1 held, req_ready=0. Then out_ready=1 -> both delivered on consecutive cycles.
- WAW: busy[5]=1; request rd=5 with non-busy sources -> stall until wb_rd=5, then advance in the same cycle, with busy[5]=1 afterwards.
- Reset mid-stall: assert reset with S1 and OUT valid and busy=0x8 -> out_valid=0, busy=0 and req_ready=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared widths and the decoded-request record used by the operand-fetch stage,
// the register file and the bench.
package operand_fetch_pkg;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    typedef struct packed {
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic [AW-1:0] rd;
        logic          wb;
    } fetch_req_t;
endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per architectural register.
// x0 never becomes busy.
module operand_fetch_scoreboard
    import operand_fetch_pkg::*;
#(
    parameter int NREGS_P = NREGS,
    parameter int AW_P    = AW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               set_en,
    input  logic [AW_P-1:0]    set_idx,
    input  logic               clr_en,
    input  logic [AW_P-1:0]    clr_idx,
    output logic [NREGS_P-1:0] busy
);

    assign busy[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NREGS_P; gi++) begin : g_bit
            logic busy_reg;
            logic set_hit;
            logic clr_hit;

            assign set_hit = set_en && (set_idx == AW_P'(gi));
            assign clr_hit = clr_en && (clr_idx == AW_P'(gi));

            // A new producer issuing in the same cycle as the old one retires
            // keeps the register busy.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    busy_reg <= 1'b0;
                end else if (set_hit) begin
                    busy_reg <= 1'b1;
                end else if (clr_hit) begin
                    busy_reg <= 1'b0;
                end
            end

            assign busy[gi] = busy_reg;
        end
    endgenerate

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: holds one accepted request, reads the register file,
// bypasses same-cycle writeback, stalls on RAW/WAW hazards and presents operands.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int XLEN_P  = XLEN,
    parameter int NREGS_P = NREGS,
    parameter int AW_P    = AW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [AW_P-1:0]    req_rs1,
    input  logic [AW_P-1:0]    req_rs2,
    input  logic [AW_P-1:0]    req_rd,
    input  logic               req_wb,
    output logic [AW_P-1:0]    rf_rd1,
    output logic [AW_P-1:0]    rf_rd2,
    input  logic [XLEN_P-1:0]  rf_rd1_data,
    input  logic [XLEN_P-1:0]  rf_rd2_data,
    input  logic               wb_valid,
    input  logic [AW_P-1:0]    wb_rd,
    input  logic [XLEN_P-1:0]  wb_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN_P-1:0]  out_op1,
    output logic [XLEN_P-1:0]  out_op2,
    output logic [AW_P-1:0]    out_rd,
    output logic               out_wb,
    output logic [NREGS_P-1:0] busy
);

    logic              s1_valid_reg;
    logic [AW_P-1:0]   s1_rs1_reg;
    logic [AW_P-1:0]   s1_rs2_reg;
    logic [AW_P-1:0]   s1_rd_reg;
    logic              s1_wb_reg;

    logic              out_valid_reg;
    logic [XLEN_P-1:0] out_op1_reg;
    logic [XLEN_P-1:0] out_op2_reg;
    logic [AW_P-1:0]   out_rd_reg;
    logic              out_wb_reg;

    logic              wb_live;
    logic              byp1;
    logic              byp2;
    logic              src1_ready;
    logic              src2_ready;
    logic              waw_stall;
    logic              advance;
    logic [XLEN_P-1:0] op1_next;
    logic [XLEN_P-1:0] op2_next;

    assign rf_rd1 = s1_valid_reg ? s1_rs1_reg : '0;
    assign rf_rd2 = s1_valid_reg ? s1_rs2_reg : '0;

    assign wb_live = wb_valid && (wb_rd != '0);
    assign byp1    = wb_live && (wb_rd == s1_rs1_reg);
    assign byp2    = wb_live && (wb_rd == s1_rs2_reg);

    assign src1_ready = (s1_rs1_reg == '0) || !busy[s1_rs1_reg] || byp1;
    assign src2_ready = (s1_rs2_reg == '0) || !busy[s1_rs2_reg] || byp2;

    assign waw_stall = s1_wb_reg && (s1_rd_reg != '0) && busy[s1_rd_reg]
                       && !(wb_valid && (wb_rd == s1_rd_reg));

    assign advance = s1_valid_reg && src1_ready && src2_ready && !waw_stall
                     && (!out_valid_reg || out_ready);

    assign req_ready = !s1_valid_reg || advance;

    // The register file is written at the same edge, so its read data is stale on a match.
    assign op1_next = (s1_rs1_reg == '0) ? '0 : (byp1 ? wb_data : rf_rd1_data);
    assign op2_next = (s1_rs2_reg == '0) ? '0 : (byp2 ? wb_data : rf_rd2_data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_rs1_reg   <= '0;
            s1_rs2_reg   <= '0;
            s1_rd_reg    <= '0;
            s1_wb_reg    <= 1'b0;
        end else if (req_valid && req_ready) begin
            s1_valid_reg <= 1'b1;
            s1_rs1_reg   <= req_rs1;
            s1_rs2_reg   <= req_rs2;
            s1_rd_reg    <= req_rd;
            s1_wb_reg    <= req_wb;
        end else if (advance) begin
            s1_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_op1_reg   <= '0;
            out_op2_reg   <= '0;
            out_rd_reg    <= '0;
            out_wb_reg    <= 1'b0;
        end else if (advance) begin
            out_valid_reg <= 1'b1;
            out_op1_reg   <= op1_next;
            out_op2_reg   <= op2_next;
            out_rd_reg    <= s1_rd_reg;
            out_wb_reg    <= s1_wb_reg;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_op1   = out_op1_reg;
    assign out_op2   = out_op2_reg;
    assign out_rd    = out_rd_reg;
    assign out_wb    = out_wb_reg;

    operand_fetch_scoreboard #(
        .NREGS_P (NREGS_P),
        .AW_P    (AW_P)
    ) u_scoreboard (
        .clk     (clk),
        .reset   (reset),
        .set_en  (advance && s1_wb_reg && (s1_rd_reg != '0)),
        .set_idx (s1_rd_reg),
        .clr_en  (wb_live),
        .clr_idx (wb_rd),
        .busy    (busy)
    );

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural register file alongside.
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [AW-1:0]    req_rs1;
    logic [AW-1:0]    req_rs2;
    logic [AW-1:0]    req_rd;
    logic             req_wb;
    logic [AW-1:0]    rf_rd1;
    logic [AW-1:0]    rf_rd2;
    logic [XLEN-1:0]  rf_rd1_data;
    logic [XLEN-1:0]  rf_rd2_data;
    logic             wb_valid;
    logic [AW-1:0]    wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_op1;
    logic [XLEN-1:0]  out_op2;
    logic [AW-1:0]    out_rd;
    logic             out_wb;
    logic [NREGS-1:0] busy;

    logic [XLEN-1:0]  rf [NREGS];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .req_rd      (req_rd),
        .req_wb      (req_wb),
        .rf_rd1      (rf_rd1),
        .rf_rd2      (rf_rd2),
        .rf_rd1_data (rf_rd1_data),
        .rf_rd2_data (rf_rd2_data),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op1     (out_op1),
        .out_op2     (out_op2),
        .out_rd      (out_rd),
        .out_wb      (out_wb),
        .busy        (busy)
    );

    // Register file: x0 deliberately holds garbage so the stage must mask it.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= 32'h100 + i;
            rf[0]  <= 32'hFFFF;
            rf[2]  <= 32'd50;
            rf[10] <= 32'd100;
        end else if (wb_valid && wb_rd != '0) begin
            rf[wb_rd] <= wb_data;
        end
    end

    assign rf_rd1_data = rf[rf_rd1];
    assign rf_rd2_data = rf[rf_rd2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-18s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input fetch_req_t r);
        req_valid = 1'b1;
        req_rs1   = r.rs1;
        req_rs2   = r.rs2;
        req_rd    = r.rd;
        req_wb    = r.wb;
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; req_rd = '0; req_wb = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_rf_rd1", 32'(rf_rd1), 32'd0);
        chk("rst_out_op1", out_op1, 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        reset = 1'b0;

        // No hazard: x2=50, x10=100 -> x3
        send('{rs1: 5'd2, rs2: 5'd10, rd: 5'd3, wb: 1'b1});
        tick();
        req_valid = 1'b0;
        chk("nh_rf_rd1", 32'(rf_rd1), 32'd2);
        chk("nh_out_valid_early", 32'(out_valid), 32'd0);
        tick();
        chk("nh_out_valid", 32'(out_valid), 32'd1);
        chk("nh_op1", out_op1, 32'd50);
        chk("nh_op2", out_op2, 32'd100);
        chk("nh_rd", 32'(out_rd), 32'd3);
        chk("nh_wb", 32'(out_wb), 32'd1);
        chk("nh_busy", busy, 32'h8);

        // RAW on x3, then bypass from writeback; new producer of x3 keeps it busy
        send('{rs1: 5'd3, rs2: 5'd0, rd: 5'd3, wb: 1'b1});
        tick();
        req_valid = 1'b0;
        chk("raw_out_valid0", 32'(out_valid), 32'd0);
        chk("raw_req_ready0", 32'(req_ready), 32'd0);
        tick();
        chk("raw_out_valid1", 32'(out_valid), 32'd0);
        chk("raw_req_ready1", 32'(req_ready), 32'd0);
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h1234;
        #1;
        chk("raw_req_ready_wb", 32'(req_ready), 32'd1);
        tick();
        wb_valid = 1'b0;
        chk("raw_out_valid", 32'(out_valid), 32'd1);
        chk("raw_op1_bypass", out_op1, 32'h1234);
        chk("raw_op2_x0", out_op2, 32'd0);
        chk("raw_busy", busy, 32'h8);

        // Make x5 busy, then a WAW on x5
        send('{rs1: 5'd0, rs2: 5'd0, rd: 5'd5, wb: 1'b1});
        tick();
        req_valid = 1'b0;
        tick();
        chk("waw_pre_busy", busy, 32'h28);
        send('{rs1: 5'd2, rs2: 5'd10, rd: 5'd5, wb: 1'b1});
        tick();
        req_valid = 1'b0;
        chk("waw_req_ready0", 32'(req_ready), 32'd0);
        tick();
        chk("waw_out_valid", 32'(out_valid), 32'd0);
        chk("waw_req_ready1", 32'(req_ready), 32'd0);
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'd7;
        #1;
        chk("waw_req_ready_wb", 32'(req_ready), 32'd1);
        tick();
        wb_valid = 1'b0;
        chk("waw_adv_valid", 32'(out_valid), 32'd1);
        chk("waw_adv_rd", 32'(out_rd), 32'd5);
        chk("waw_adv_op1", out_op1, 32'd50);
        chk("waw_busy", busy, 32'h28);

        // x0 operands and destination
        send('{rs1: 5'd0, rs2: 5'd0, rd: 5'd0, wb: 1'b1});
        tick();
        req_valid = 1'b0;
        tick();
        chk("x0_valid", 32'(out_valid), 32'd1);
        chk("x0_op1", out_op1, 32'd0);
        chk("x0_op2", out_op2, 32'd0);
        chk("x0_rd", 32'(out_rd), 32'd0);
        chk("x0_busy", busy, 32'h28);

        // Back-pressure: OUT holds x0 result, A sits in S1, B waits
        out_ready = 1'b0;
        send('{rs1: 5'd2, rs2: 5'd2, rd: 5'd6, wb: 1'b0});
        tick();
        send('{rs1: 5'd10, rs2: 5'd10, rd: 5'd7, wb: 1'b0});
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_rd", 32'(out_rd), 32'd0);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_s1_rd1", 32'(rf_rd1), 32'd2);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        chk("bp_a_valid", 32'(out_valid), 32'd1);
        chk("bp_a_rd", 32'(out_rd), 32'd6);
        chk("bp_a_op1", out_op1, 32'd50);
        tick();
        chk("bp_b_valid", 32'(out_valid), 32'd1);
        chk("bp_b_rd", 32'(out_rd), 32'd7);
        chk("bp_b_op2", out_op2, 32'd100);

        // Retire x5, fill S1 while OUT is blocked, then reset between edges
        out_ready = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'd9;
        send('{rs1: 5'd0, rs2: 5'd0, rd: 5'd8, wb: 1'b0});
        tick();
        wb_valid = 1'b0; req_valid = 1'b0;
        chk("rm_busy", busy, 32'h8);
        chk("rm_out_valid", 32'(out_valid), 32'd1);
        chk("rm_req_ready", 32'(req_ready), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("rm_async_valid", 32'(out_valid), 32'd0);
        chk("rm_async_busy", busy, 32'd0);
        chk("rm_async_ready", 32'(req_ready), 32'd1);
        chk("rm_async_rd1", 32'(rf_rd1), 32'd0);
        tick();
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
